// File: rtl/seg_mem_ctl.sv
// Segmented data memory for the mixer DSP core: RF, double-buffered sample IO and host-writable PMEM.
// Define SEG_ERR_EN to build the sticky unmapped-segment flag and saturating access counter.
module seg_mem_ctl #(
  parameter int DAW  = 10,
  parameter int UDAW = 7,
  parameter int DWW  = 36,
  parameter int NIO  = 8,
  parameter int PAW  = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DAW-1:0]     addrA,
  output logic [DWW-1:0]     dataA,
  input  logic [DAW-1:0]     addrB,
  output logic [DWW-1:0]     dataB,
  output logic               stall,
  input  logic [DAW-1:0]     addrW,
  input  logic [DWW-1:0]     dataW,
  input  logic               writeEn,
  input  logic               sampleStrobe,
  input  logic [NIO*DWW-1:0] inputs,
  output logic [NIO*DWW-1:0] outputs,
  input  logic [PAW-1:0]     hostAddr,
  input  logic [DWW-1:0]     hostData,
  input  logic               hostValid,
  output logic               hostReady,
  output logic               segErr,
  output logic [7:0]         segErrCount
);

  localparam int SW  = DAW - UDAW;
  localparam int CW  = (NIO > 1) ? $clog2(NIO) : 1;
  localparam int RFD = 1 << UDAW;
  localparam int PMD = 1 << PAW;

  localparam logic [SW-1:0] SEG_RF = SW'(0);
  localparam logic [SW-1:0] SEG_IO = SW'(1);
  localparam logic [SW-1:0] SEG_PM = SW'(2);

  typedef enum logic {ST_RUN, ST_CONFLICT} state_t;

  state_t         state_q;
  logic           stall_q;
  logic           ready_q;
  logic [DWW-1:0] data_a_q;
  logic [DWW-1:0] data_b_q;

  logic [1:0][DAW-1:0]  port_addr;
  logic [1:0][SW-1:0]   port_seg;
  logic [1:0][UDAW-1:0] port_off;
  logic [1:0][DWW-1:0]  port_rd;

  logic [SW-1:0]   seg_w;
  logic [UDAW-1:0] off_w;
  logic [CW-1:0]   ch_w;
  logic            w_ok;
  logic            w_rf;
  logic            w_io;
  logic            w_pm;
  logic            conflict;
  logic            host_fire;

  logic [DWW-1:0]     rf_mem [RFD];
  logic [DWW-1:0]     pm_mem [PMD];
  logic [PAW-1:0]     pm_raddr;
  logic [DWW-1:0]     pm_rd;
  logic [NIO*DWW-1:0] in_bus;

  assign port_addr = {addrB, addrA};
  assign seg_w     = addrW[DAW-1:UDAW];
  assign off_w     = addrW[UDAW-1:0];
  assign ch_w      = off_w[CW-1:0];

  // Writes presented while stalled are dropped; the core re-presents them afterwards.
  assign w_ok = writeEn && !stall_q && rst_n;
  assign w_rf = w_ok && (seg_w == SEG_RF);
  assign w_io = w_ok && (seg_w == SEG_IO);
  assign w_pm = w_ok && (seg_w == SEG_PM);

  assign conflict = (state_q == ST_RUN) &&
                    (port_seg[0] == SEG_PM) && (port_seg[1] == SEG_PM) &&
                    (port_off[0][PAW-1:0] != port_off[1][PAW-1:0]);

  // A owns the single PMEM read port in RUN; B gets it during the CONFLICT cycle.
  assign pm_raddr = ((state_q == ST_RUN) && (port_seg[0] == SEG_PM)) ?
                    port_off[0][PAW-1:0] : port_off[1][PAW-1:0];
  assign pm_rd    = pm_mem[pm_raddr];

  assign hostReady = ready_q && !w_pm;
  assign host_fire = hostValid && hostReady && rst_n;

  genvar gi;

  for (gi = 0; gi < 2; gi++) begin : g_port
    logic [DWW-1:0] rd;

    assign port_seg[gi] = port_addr[gi][DAW-1:UDAW];
    assign port_off[gi] = port_addr[gi][UDAW-1:0];

    always_comb begin
      rd = '0;
      case (port_seg[gi])
        SEG_RF:  rd = (w_rf && (off_w == port_off[gi])) ? dataW : rf_mem[port_off[gi]];
        SEG_IO:  rd = in_bus[int'(port_off[gi][CW-1:0])*DWW +: DWW];
        SEG_PM:  rd = pm_rd;
        default: rd = '0;
      endcase
    end

    assign port_rd[gi] = rd;
  end

  always_ff @(posedge clk) begin
    if (w_rf) begin
      rf_mem[off_w] <= dataW;
    end
  end

  // Core writes win the PMEM write port; hostReady is already low in that cycle.
  always_ff @(posedge clk) begin
    if (w_pm) begin
      pm_mem[off_w[PAW-1:0]] <= dataW;
    end else if (host_fire) begin
      pm_mem[hostAddr] <= hostData;
    end
  end

  for (gi = 0; gi < NIO; gi++) begin : g_io
    logic [DWW-1:0] in_q;
    logic [DWW-1:0] work_q;
    logic [DWW-1:0] out_q;

    // Strobe copies the old work word; a same-cycle write lands after the copy.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        in_q   <= '0;
        work_q <= '0;
        out_q  <= '0;
      end else begin
        if (sampleStrobe) begin
          in_q  <= inputs[gi*DWW +: DWW];
          out_q <= work_q;
        end
        if (w_io && (ch_w == CW'(gi))) begin
          work_q <= dataW;
        end
      end
    end

    assign in_bus[gi*DWW +: DWW]  = in_q;
    assign outputs[gi*DWW +: DWW] = out_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      stall_q  <= 1'b0;
      ready_q  <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      ready_q <= 1'b1;
      case (state_q)
        ST_RUN: begin
          data_a_q <= port_rd[0];
          if (conflict) begin
            state_q <= ST_CONFLICT;
            stall_q <= 1'b1;
          end else begin
            data_b_q <= port_rd[1];
          end
        end
        ST_CONFLICT: begin
          data_b_q <= port_rd[1];
          state_q  <= ST_RUN;
          stall_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_RUN;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign dataA = data_a_q;
  assign dataB = data_b_q;
  assign stall = stall_q;

`ifdef SEG_ERR_EN
  localparam logic [SW-1:0] SEG_BAD = SW'(3);

  logic       offend;
  logic       err_q;
  logic [7:0] cnt_q;

  assign offend = (port_seg[0] >= SEG_BAD) || (port_seg[1] >= SEG_BAD) ||
                  (w_ok && (seg_w >= SEG_BAD));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (offend) begin
      err_q <= 1'b1;
      if (cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign segErr      = err_q;
  assign segErrCount = cnt_q;
`else
  assign segErr      = 1'b0;
  assign segErrCount = '0;
`endif

endmodule

// File: tb/tb_seg_mem_ctl.sv
// Randomised scoreboard bench for seg_mem_ctl: a cycle-level reference model pushes expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_seg_mem_ctl;
  localparam int DAW  = 10;
  localparam int UDAW = 7;
  localparam int DWW  = 36;
  localparam int NIO  = 8;
  localparam int PAW  = 7;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [DAW-1:0]     addrA, addrB, addrW;
  logic [DWW-1:0]     dataA, dataB, dataW;
  logic               stall, writeEn, sampleStrobe;
  logic [NIO*DWW-1:0] inputs, outputs;
  logic [PAW-1:0]     hostAddr;
  logic [DWW-1:0]     hostData;
  logic               hostValid, hostReady;
  logic               segErr;
  logic [7:0]         segErrCount;

  seg_mem_ctl #(.DAW(DAW), .UDAW(UDAW), .DWW(DWW), .NIO(NIO), .PAW(PAW)) dut (
    .clk(clk), .rst_n(rst_n),
    .addrA(addrA), .dataA(dataA), .addrB(addrB), .dataB(dataB), .stall(stall),
    .addrW(addrW), .dataW(dataW), .writeEn(writeEn), .sampleStrobe(sampleStrobe),
    .inputs(inputs), .outputs(outputs),
    .hostAddr(hostAddr), .hostData(hostData), .hostValid(hostValid), .hostReady(hostReady),
    .segErr(segErr), .segErrCount(segErrCount)
  );

  always #5 clk = ~clk;

  typedef enum int {K_A, K_B, K_STALL, K_HRDY, K_OUT, K_ERR, K_CNT} kind_t;
  typedef struct {
    int             cyc;
    kind_t          kind;
    int             idx;
    logic [DWW-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [DWW-1:0] m_rf   [128];
  logic [DWW-1:0] m_pm   [128];
  logic [DWW-1:0] m_in   [NIO];
  logic [DWW-1:0] m_work [NIO];
  logic [DWW-1:0] m_out  [NIO];
  logic [DWW-1:0] m_last_a, m_last_b;
  bit             m_stall, m_ready, m_err;
  int             m_cnt;

  // Per-cycle core/host drive
  logic [DAW-1:0] d_a, d_b, d_w;
  logic [DWW-1:0] d_wd, d_hd;
  logic [PAW-1:0] d_ha;
  bit             d_we, d_stb, d_hv;

  function automatic void push(int c, kind_t k, int i, logic [DWW-1:0] v);
    exp_t e;
    e.cyc = c; e.kind = k; e.idx = i; e.val = v;
    sb.push_back(e);
  endfunction

  function automatic string kname(kind_t k);
    case (k)
      K_A:     return "dataA";
      K_B:     return "dataB";
      K_STALL: return "stall";
      K_HRDY:  return "hostReady";
      K_OUT:   return "outputs";
      K_ERR:   return "segErr";
      default: return "segErrCount";
    endcase
  endfunction

  function automatic logic [DWW-1:0] actual(kind_t k, int i);
    case (k)
      K_A:     return dataA;
      K_B:     return dataB;
      K_STALL: return DWW'(stall);
      K_HRDY:  return DWW'(hostReady);
      K_OUT:   return outputs[i*DWW +: DWW];
      K_ERR:   return DWW'(segErr);
      default: return DWW'(segErrCount);
    endcase
  endfunction

  function automatic logic [DWW-1:0] model_read(int s, int o, bit acc_w, int sw, int ow);
    case (s)
      0:       return (acc_w && sw == 0 && ow == o) ? d_wd : m_rf[o];
      1:       return m_in[o % NIO];
      2:       return m_pm[o];
      default: return '0;
    endcase
  endfunction

  function automatic logic [DAW-1:0] rand_addr();
    int r;
    logic [2:0] s;
    logic [6:0] o;
    r = $urandom_range(0, 99);
    if (r < 30)      s = 3'd0;
    else if (r < 55) s = 3'd1;
    else if (r < 92) s = 3'd2;
    else             s = 3'($urandom_range(3, 7));
    o = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 11));
    return {s, o};
  endfunction

  function automatic logic [DWW-1:0] rand_word();
    return DWW'({$urandom(), $urandom()});
  endfunction

  task automatic idle();
    d_a = '0; d_b = '0; d_w = '0; d_wd = '0; d_we = 0; d_stb = 0;
    d_hv = 0; d_ha = '0; d_hd = '0;
  endtask

  // Drive one cycle, derive its effects from the memory-map rules, then advance.
  task automatic tick();
    logic [DWW-1:0] rd_a, rd_b, exp_a, exp_b;
    bit acc_w, conflict, hrdy;
    int sa, sbg, sw, oa, ob, ow;
    addrA = d_a; addrB = d_b; addrW = d_w; dataW = d_wd; writeEn = d_we;
    sampleStrobe = d_stb; hostValid = d_hv; hostAddr = d_ha; hostData = d_hd;
    sa  = int'(d_a[DAW-1:UDAW]); oa = int'(d_a[UDAW-1:0]);
    sbg = int'(d_b[DAW-1:UDAW]); ob = int'(d_b[UDAW-1:0]);
    sw  = int'(d_w[DAW-1:UDAW]); ow = int'(d_w[UDAW-1:0]);
    acc_w = d_we && !m_stall;
    hrdy  = m_ready && !(acc_w && sw == 2);
    push(cyc, K_HRDY, 0, DWW'(hrdy));
    rd_a = model_read(sa, oa, acc_w, sw, ow);
    rd_b = model_read(sbg, ob, acc_w, sw, ow);
    conflict = !m_stall && sa == 2 && sbg == 2 && oa != ob;
    exp_a = m_stall ? m_last_a : rd_a;
    exp_b = conflict ? m_last_b : rd_b;
    push(cyc + 1, K_A, 0, exp_a);
    push(cyc + 1, K_B, 0, exp_b);
    push(cyc + 1, K_STALL, 0, DWW'(conflict));
`ifdef SEG_ERR_EN
    if (sa >= 3 || sbg >= 3 || (acc_w && sw >= 3)) begin
      m_err = 1;
      if (m_cnt < 255) m_cnt++;
    end
`endif
    push(cyc + 1, K_ERR, 0, DWW'(m_err));
    push(cyc + 1, K_CNT, 0, DWW'(m_cnt));
    if (d_stb) begin
      for (int ch = 0; ch < NIO; ch++) begin
        m_out[ch] = m_work[ch];
        m_in[ch]  = inputs[ch*DWW +: DWW];
      end
    end
    if (acc_w) begin
      case (sw)
        0:       m_rf[ow] = d_wd;
        1:       m_work[ow % NIO] = d_wd;
        2:       m_pm[ow] = d_wd;
        default: ;
      endcase
    end
    if (d_hv && hrdy) m_pm[int'(d_ha)] = d_hd;
    for (int ch = 0; ch < NIO; ch++) push(cyc + 1, K_OUT, ch, m_out[ch]);
    m_last_a = exp_a;
    m_last_b = exp_b;
    m_stall  = conflict;
    m_ready  = 1;
    @(posedge clk);
    #1;
  endtask

  // One reset cycle with addresses held; RF and PMEM contents survive.
  task automatic do_reset();
    rst_n = 1'b0; writeEn = 1'b0; hostValid = 1'b0; sampleStrobe = 1'b0;
    push(cyc + 1, K_A, 0, '0);
    push(cyc + 1, K_B, 0, '0);
    push(cyc + 1, K_STALL, 0, '0);
    push(cyc + 1, K_HRDY, 0, '0);
    push(cyc + 1, K_ERR, 0, '0);
    push(cyc + 1, K_CNT, 0, '0);
    for (int ch = 0; ch < NIO; ch++) begin
      push(cyc + 1, K_OUT, ch, '0);
      m_in[ch] = '0; m_work[ch] = '0; m_out[ch] = '0;
    end
    m_last_a = '0; m_last_b = '0; m_stall = 0; m_ready = 0; m_err = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every expectation due this cycle is compared, stale ones count as misses.
  always @(negedge clk) begin
    logic [DWW-1:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act = actual(sb[i].kind, sb[i].idx);
        checks++;
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s[%0d] cyc=%0d got=%h expected=%h",
                   kname(sb[i].kind), sb[i].idx, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s[%0d] never sampled, due cyc=%0d", kname(sb[i].kind), sb[i].idx, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; addrA = '0; addrB = '0; addrW = '0; dataW = '0; writeEn = 1'b0;
    sampleStrobe = 1'b0; inputs = '0; hostAddr = '0; hostData = '0; hostValid = 1'b0;
    m_stall = 0; m_ready = 0; m_err = 0; m_cnt = 0;
    idle();
    @(posedge clk);
    #1;
    do_reset();

    // Fill RF and PMEM so every later read has a known model value
    for (int i = 0; i < 128; i++) begin
      idle(); d_we = 1; d_w = DAW'(i); d_wd = rand_word(); tick();
      idle(); d_we = 1; d_w = DAW'(256 + i); d_wd = rand_word(); tick();
    end

    $display("tx rf write 0x005 with same-cycle read, then readback");
    idle(); d_we = 1; d_w = 10'h005; d_wd = 36'h123456789; d_a = 10'h005;
    push(cyc + 1, K_A, 0, 36'h123456789); tick();
    idle(); d_a = 10'h005; push(cyc + 1, K_A, 0, 36'h123456789); tick();

    $display("tx io frame capture and output double buffer");
    idle(); inputs[3*DWW +: DWW] = 36'hAAA; d_stb = 1; tick();
    idle(); inputs[3*DWW +: DWW] = 36'hBBB; d_a = 10'h083; push(cyc + 1, K_A, 0, 36'hAAA); tick();
    idle(); d_we = 1; d_w = 10'h082; d_wd = 36'h55; push(cyc + 1, K_OUT, 2, '0); tick();
    idle(); push(cyc + 1, K_OUT, 2, '0); tick();
    idle(); d_stb = 1; push(cyc + 1, K_OUT, 2, 36'h55); tick();

    $display("tx pmem host writes then A/B conflict");
    idle(); d_hv = 1; d_ha = 7'd4; d_hd = 36'h11; push(cyc, K_HRDY, 0, 1); tick();
    idle(); d_hv = 1; d_ha = 7'd9; d_hd = 36'h22; tick();
    idle(); d_a = 10'h104; d_b = 10'h109;
    push(cyc + 1, K_STALL, 0, 1); push(cyc + 1, K_A, 0, 36'h11); tick();
    push(cyc + 1, K_B, 0, 36'h22); push(cyc + 1, K_STALL, 0, 0); tick();
    idle(); d_a = 10'h104; d_b = 10'h104;
    push(cyc + 1, K_STALL, 0, 0); push(cyc + 1, K_A, 0, 36'h11); push(cyc + 1, K_B, 0, 36'h11); tick();

    $display("tx host write blocked by core pmem write");
    idle(); d_hv = 1; d_ha = 7'd12; d_hd = 36'h77; d_we = 1; d_w = 10'h10A; d_wd = 36'h66;
    push(cyc, K_HRDY, 0, 0); tick();
    d_we = 0; push(cyc, K_HRDY, 0, 1); tick();
    idle(); d_a = 10'h10A; d_b = 10'h10C; push(cyc + 1, K_A, 0, 36'h66); tick();
    push(cyc + 1, K_B, 0, 36'h77); tick();

    $display("tx unmapped reads and counter saturation");
    idle(); d_a = 10'h3FF; push(cyc + 1, K_A, 0, '0);
`ifdef SEG_ERR_EN
    push(cyc + 1, K_ERR, 0, 1); push(cyc + 1, K_CNT, 0, 1);
`else
    push(cyc + 1, K_ERR, 0, 0); push(cyc + 1, K_CNT, 0, 0);
`endif
    tick();
    for (int i = 0; i < 300; i++) tick();
`ifdef SEG_ERR_EN
    push(cyc, K_CNT, 0, 255);
`else
    push(cyc, K_CNT, 0, 0);
`endif
    idle(); do_reset(); tick();

    $display("tx reset during conflict");
    idle(); d_a = 10'h104; d_b = 10'h109; tick();
    push(cyc, K_STALL, 0, 1);
    do_reset();
    idle(); tick(); tick();

    $display("tx randomised traffic");
    for (int n = 0; n < 1500; n++) begin
      if (!m_stall) begin
        d_a  = rand_addr();
        d_b  = rand_addr();
        d_w  = rand_addr();
        d_wd = rand_word();
        d_we = ($urandom_range(0, 2) == 0);
      end
      d_stb = ($urandom_range(0, 7) == 0);
      d_hv  = ($urandom_range(0, 1) == 1);
      d_ha  = PAW'($urandom_range(0, 15));
      d_hd  = rand_word();
      if ($urandom_range(0, 3) == 0) begin
        for (int ch = 0; ch < NIO; ch++) inputs[ch*DWW +: DWW] = rand_word();
      end
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick();
    end

    idle(); tick(); tick(); tick();
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_mem_ctl.md
Name: seg_mem_ctl

Overview:
- Parametrised segmented data-memory controller for the mixer DSP core.
- Serves two read ports (A, B) and one write port (W) over three segments: register file, double-buffered sample IO, and parameter memory.
- Parameter memory is host-writable through a valid/ready port.
- All core reads are registered. A stall handshake resolves A/B contention on the single parameter-memory read port.

Parameters:
DAW, 10, segmented address width (segment bits on top)
UDAW, 7, in-segment address width; segment width SW = DAW-UDAW
DWW, 36, data word width
NIO, 8, IO channels per direction (power of two, ≤ 2^UDAW)
PAW, 7, parameter memory address width (≤ UDAW)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
addrA  in  DAW  read port A address
dataA  out  DWW  read data A, valid 1 cycle after addrA
addrB  in  DAW  read port B address
dataB  out  DWW  read data B, valid 1 cycle after addrB (unless stalled)
stall  out  1  core must hold addrA/addrB/W inputs this cycle
addrW  in  DAW  write address
dataW  in  DWW  write data
writeEn  in  1  write strobe
sampleStrobe  in  1  frame boundary, one pulse per audio sample
inputs  in  NIO×DWW  ADC-side sample bus
outputs  out  NIO×DWW  DAC-side sample bus
hostAddr  in  PAW  host parameter write address
hostData  in  DWW  host parameter write data
hostValid  in  1  host write request
hostReady  out  1  host write accepted when hostValid && hostReady
segErr  out  1  sticky unmapped-segment flag (SEG_ERR_EN)
segErrCount  out  8  unmapped access count (SEG_ERR_EN)

Behaviour:
- Reset (rst_n=0 at clk edge): dataA/dataB=0, stall=0, outputs=0, input bank=0, output work bank=0, FSM=RUN, segErr=0, segErrCount=0, hostReady=0. RF and PMEM contents are not cleared.
- hostReady is 1 from the first cycle after reset release, except as noted below.
- Decode: seg = addr[DAW-1:UDAW], off = addr[UDAW-1:0].
  - Segment 0: RF.
  - Segment 1: IO; channel = off mod NIO.
  - Segment 2: PMEM; address = off[PAW-1:0].
  - Segments ≥3: unmapped; reads return 0, writes are dropped.
- Read latency is exactly 1 cycle for every segment. dataA/dataB are registered.
- RF: 2 read ports, 1 write port. Read-during-write to the same offset returns the new data (bypass).
- IO inputs:
  - On sampleStrobe, inputs are captured into the input bank.
  - Core reads of segment 1 see the input bank only, so values are stable for the whole frame.
- IO outputs:
  - Core writes to segment 1 go to the work bank.
  - On sampleStrobe, work bank is copied to outputs.
  - A write and a strobe in the same cycle: the write lands in the work bank after the copy, so it appears at the next strobe.
- PMEM has one read port and one write port. Read-during-write returns old data.
- Contention FSM:
  - RUN → CONFLICT when A and B both address seg 2 at different offsets. A is served that cycle; stall=1; dataB is not updated.
  - CONFLICT: B is served (dataA holds its previous value), stall=0, → RUN.
  - Same offset on A and B: no conflict; both ports get the same word.
- While stall=1, W-port writes are ignored. The core re-presents them.
- PMEM write arbitration:
  - A core write to seg 2 has priority: hostReady=0 that cycle.
  - Otherwise a host write completes on the hostValid && hostReady edge.
- Reset mid-CONFLICT returns the FSM to RUN with stall=0. A pending host transfer is dropped.

Optional Feature:
- Macro: SEG_ERR_EN.
- Defined:
  - Any read (A or B) or write to seg ≥3 sets segErr (sticky until reset).
  - segErrCount increments by 1 per offending cycle and saturates at 255.
- Undefined: segErr and segErrCount are tied to 0, and no counter logic is generated.

Test Plan:
- RF write/read: write 0x123456789 to addr 0x005; next cycle read A=0x005 → dataA=0x123456789 one cycle later. Same-cycle read of 0x005 during the write → new value (bypass).
- IO frame: inputs[3]=0xAAA, strobe; inputs[3]→0xBBB without strobe; read 0x083 → 0xAAA. Write 0x55 to 0x082 → outputs[2] stays 0 until the next strobe, then =0x55.
- PMEM conflict: host writes 0x11 to 4 and 0x22 to 9. A=0x104, B=0x109 → stall=1 for 1 cycle, dataA=0x11 at cycle+1, dataB=0x22 at cycle+2. A=B=0x104 → no stall, both 0x11.
- Host arbitration: hostValid held with a core write to 0x10A in the same cycle → hostReady=0, host write lands the next cycle. Readback shows both values.
- Unmapped (SEG_ERR_EN): read 0x3FF → dataA=0, segErr=1, count=1. 300 offending cycles → count=255. Reset → both 0.
- Reset mid-stall: assert rst_n=0 during CONFLICT → next cycle stall=0, outputs=0, hostReady=0.
